// File: rtl/vgpr_wr_port_arbiter_pkg.sv
// Shared VGPR write-path definitions: port counts, select bus width, index type.
package vgpr_wr_port_arbiter_pkg;

   localparam int unsigned NUM_WR_PORTS = 8;
   localparam int unsigned AUX_PORT_IDX = 8;
   localparam int unsigned WR_SEL_W     = 16;

   typedef logic [3:0] wr_port_idx_t;

   // Which requester class wins the current arbitration round.
   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_PORT,
      GRANT_AUX
   } grant_kind_e;

   // Zero-extended one-hot mux select built from the registered grants.
   function automatic logic [WR_SEL_W-1:0] sel_from_grants(
      input logic [NUM_WR_PORTS-1:0] gnt,
      input logic                    aux_gnt
   );
      logic [WR_SEL_W-1:0] sel;
      sel                    = '0;
      sel[NUM_WR_PORTS-1:0]  = gnt;
      sel[AUX_PORT_IDX]      = aux_gnt;
      return sel;
   endfunction

endpackage

// File: rtl/vgpr_wr_port_arbiter_rr_pick8.sv
// Rotate-priority encoder: first eligible port at or after the pointer, wrapping 7 to 0.
module rr_pick8
   import vgpr_wr_port_arbiter_pkg::*;
(
   input  logic [NUM_WR_PORTS-1:0] elig_i,
   input  logic [2:0]              ptr_i,
   output logic [NUM_WR_PORTS-1:0] win_o,
   output logic                    valid_o
);

   logic [2:0] idx;

   // Walk ports in pointer order and keep the first eligible one.
   always_comb begin
      win_o   = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
         idx = ptr_i + k[2:0];
         if (!valid_o && elig_i[idx]) begin
            win_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vgpr_wr_port_arbiter.sv
// Round-robin VGPR write-port arbiter: eight FU ports plus an aux port, one grant per cycle.
module vgpr_wr_port_arbiter
   import vgpr_wr_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_WR_PORTS-1:0] req,
   input  logic                    aux_req,
   output logic [NUM_WR_PORTS-1:0] gnt,
   output logic                    aux_gnt,
   output logic [WR_SEL_W-1:0]     wr_port_select,
   output logic                    busy
);

   logic [NUM_WR_PORTS-1:0] gnt_q, gnt_d;
   logic                    aux_gnt_q, aux_gnt_d;
   logic                    busy_q, busy_d;
   logic [2:0]              ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [NUM_WR_PORTS-1:0] port_elig;
   logic                    aux_elig;
   logic [NUM_WR_PORTS-1:0] rr_win;
   logic                    rr_valid;
   logic                    starve_hit;
   grant_kind_e             kind;
   wr_port_idx_t            win_idx;

   // Last cycle's grant doubles as the mask: requesters still hold req during their grant cycle.
   always_comb begin
      port_elig = req & ~gnt_q;
      aux_elig  = aux_req & ~aux_gnt_q;
   end

   rr_pick8 u_rr_pick8 (
      .elig_i  (port_elig),
      .ptr_i   (ptr_q),
      .win_o   (rr_win),
      .valid_o (rr_valid)
   );

   // Aux has priority unless ports have been starved for STARVE_LIMIT aux grants.
   always_comb begin
      kind       = GRANT_NONE;
      starve_hit = (cnt_q == CNT_W'(STARVE_LIMIT));
      if (aux_elig && !(starve_hit && rr_valid)) begin
         kind = GRANT_AUX;
      end else if (rr_valid) begin
         kind = GRANT_PORT;
      end
   end

   // Binary index of the round-robin winner for the pointer update.
   always_comb begin
      win_idx = '0;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
         if (rr_win[k]) begin
            win_idx = wr_port_idx_t'(k);
         end
      end
   end

   // Next grant, pointer and starvation counter.
   always_comb begin
      gnt_d     = '0;
      aux_gnt_d = 1'b0;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      busy_d    = rr_valid | aux_elig;
      case (kind)
         GRANT_PORT: begin
            gnt_d = rr_win;
            ptr_d = 3'(win_idx + wr_port_idx_t'(1));
            cnt_d = '0;
         end
         GRANT_AUX: begin
            aux_gnt_d = 1'b1;
            if (rr_valid && !starve_hit) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         aux_gnt_q <= 1'b0;
         busy_q    <= 1'b0;
         ptr_q     <= '0;
         cnt_q     <= '0;
      end else begin
         gnt_q     <= gnt_d;
         aux_gnt_q <= aux_gnt_d;
         busy_q    <= busy_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt            = gnt_q;
   assign aux_gnt        = aux_gnt_q;
   assign busy           = busy_q;
   assign wr_port_select = sel_from_grants(gnt_q, aux_gnt_q);

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Scoreboard bench for vgpr_wr_port_arbiter with a behavioural arbitration model.
module tb_vgpr_wr_port_arbiter;

   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned CNT_W        = 3;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic        aux_req;
   logic [7:0]  gnt;
   logic        aux_gnt;
   logic [15:0] wr_port_select;
   logic        busy;

   vgpr_wr_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .aux_req        (aux_req),
      .gnt            (gnt),
      .aux_gnt        (aux_gnt),
      .wr_port_select (wr_port_select),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sel;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   sb_en = 1'b0;

   // Model state: which port/aux was granted last cycle, search start, starvation count.
   int   m_ptr;
   int   m_last_port;
   bit   m_last_aux;
   int   m_starve;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr       = 0;
      m_last_port = -1;
      m_last_aux  = 1'b0;
      m_starve    = 0;
   endtask

   // Decide the grant the arbiter must issue for request vector r / aux a at the next edge.
   task automatic model_step(input logic [7:0] r, input logic a);
      int   win;
      int   chosen;
      bit   aux_e;
      exp_t e;
      win = -1;
      for (int k = 0; k < 8; k++) begin
         int p;
         p = (m_ptr + k) % 8;
         if (win < 0 && r[p] && p != m_last_port) win = p;
      end
      aux_e = a && !m_last_aux;
      if (aux_e && !(m_starve == STARVE_LIMIT && win >= 0)) chosen = 8;
      else chosen = win;
      e.sel  = (chosen >= 0) ? (16'd1 << chosen) : 16'd0;
      e.busy = aux_e || (win >= 0);
      exp_q.push_back(e);
      if (chosen == 8) begin
         if (win >= 0 && m_starve < STARVE_LIMIT) m_starve++;
         m_last_aux  = 1'b1;
         m_last_port = -1;
      end else if (chosen >= 0) begin
         m_ptr       = (chosen + 1) % 8;
         m_starve    = 0;
         m_last_port = chosen;
         m_last_aux  = 1'b0;
      end else begin
         m_last_port = -1;
         m_last_aux  = 1'b0;
      end
   endtask

   // Called at a falling edge: apply inputs, record expectation, advance one cycle.
   task automatic drive(input logic [7:0] r, input logic a);
      req     = r;
      aux_req = a;
      model_step(r, a);
      @(negedge clk);
   endtask

   // Monitor: after each rising edge, pop the expected response and check invariants.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         logic [15:0] hi;
         hi = wr_port_select & 16'hFE00;
         check("sel_upper_zero", hi, 16'h0000);
         check("sel_onehot", 16'($countones(wr_port_select) <= 1), 16'd1);
         check("gnt_vs_sel", {7'd0, aux_gnt, gnt}, {7'd0, wr_port_select[8:0]});
      end
      if (sb_en && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("wr_port_select", wr_port_select, e.sel);
         check("busy", {15'd0, busy}, {15'd0, e.busy});
      end
   end

   initial begin
      logic [7:0] r;
      rst_n   = 1'b0;
      req     = '0;
      aux_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", wr_port_select, 16'h0000);
      check("rst_gnt", {8'd0, gnt}, 16'h0000);
      check("rst_aux", {15'd0, aux_gnt}, 16'h0000);
      check("rst_busy", {15'd0, busy}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      sb_en = 1'b1;

      // Idle after reset.
      repeat (10) drive(8'h00, 1'b0);
      // Single port held: mask gap between grants.
      repeat (5) drive(8'h04, 1'b0);
      repeat (2) drive(8'h00, 1'b0);
      // All ports held: full rotation and wrap.
      repeat (10) drive(8'hFF, 1'b0);
      repeat (2) drive(8'h00, 1'b0);
      // Aux plus port 0 held.
      repeat (8) drive(8'h01, 1'b1);
      repeat (2) drive(8'h00, 1'b0);
      // Port requests only on aux-eligible cycles: counter climbs to the limit, then port 0 wins.
      for (int i = 0; i < 12; i++) drive((i % 2 == 0) ? 8'h01 : 8'h00, 1'b1);
      repeat (3) drive(8'h00, 1'b0);

      // Reset while port 4 holds a grant.
      sb_en   = 1'b0;
      req     = 8'h10;
      aux_req = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_gnt", {8'd0, gnt}, 16'h0010);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_sel", wr_port_select, 16'h0000);
      check("mid_rst_gnt", {8'd0, gnt}, 16'h0000);
      check("mid_rst_aux", {15'd0, aux_gnt}, 16'h0000);
      check("mid_rst_busy", {15'd0, busy}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      exp_q.delete();
      sb_en = 1'b1;
      drive(8'h10, 1'b0);
      repeat (2) drive(8'h00, 1'b0);

      // Random traffic with partially held requests.
      r = '0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 1) == 0) r = 8'($urandom);
         else if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
         drive(r, ($urandom_range(0, 2) == 0));
      end
      drive(8'h00, 1'b0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
